// File: rtl/sbqm_beam_encoder.sv
// sbqm_beam_encoder: debounces two entrance photo-beams and decodes passages into enter/leave/err pulses
module sbqm_beam_encoder #(
   parameter int DEB_CYCLES = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic beam_a,
   input  logic beam_b,
   output logic enter,
   output logic leave,
   output logic err,
   output logic busy,
   output logic a_clean,
   output logic b_clean
);
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, A1, AB, B2, B1, BA, A2, WAIT_CLR} state_t;
   logic [1:0] sync_a, sync_b;
   logic [DW-1:0] cnt_a, cnt_b;
   logic [TW-1:0] dwell;
   logic [1:0] ab;
   logic enter_n, leave_n, err_n, timed_out;
   state_t state, state_n;
   assign ab = {a_clean, b_clean};
   // two-flop synchronizers followed by per-beam debounce counters; clean toggles on the DEB_CYCLES-th consecutive mismatching sample
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= '0;
         sync_b <= '0;
         cnt_a <= '0;
         cnt_b <= '0;
         a_clean <= 1'b0;
         b_clean <= 1'b0;
      end else begin
         sync_a <= {sync_a[0], beam_a};
         sync_b <= {sync_b[0], beam_b};
         cnt_a <= (sync_a[1] == a_clean || cnt_a == DW'(DEB_CYCLES - 1)) ? '0 : cnt_a + 1'b1;
         cnt_b <= (sync_b[1] == b_clean || cnt_b == DW'(DEB_CYCLES - 1)) ? '0 : cnt_b + 1'b1;
         a_clean <= (sync_a[1] != a_clean && cnt_a == DW'(DEB_CYCLES - 1)) ? ~a_clean : a_clean;
         b_clean <= (sync_b[1] != b_clean && cnt_b == DW'(DEB_CYCLES - 1)) ? ~b_clean : b_clean;
      end
   end
   // passage decoder: next state and pulse requests, timeout overriding any beam change
   always_comb begin
      state_n = state;
      enter_n = 1'b0;
      leave_n = 1'b0;
      err_n = 1'b0;
      timed_out = state != IDLE && state != WAIT_CLR && dwell == TW'(TIMEOUT - 1);
      if (timed_out) begin
         state_n = WAIT_CLR;
         err_n = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               state_n = ab == 2'b10 ? A1 : ab == 2'b01 ? B1 : ab == 2'b11 ? WAIT_CLR : IDLE;
               err_n = ab == 2'b11;
            end
            A1: state_n = ab == 2'b00 ? IDLE : ab == 2'b11 ? AB : A1;
            AB: begin
               state_n = ab == 2'b10 ? A1 : ab == 2'b01 ? B2 : ab == 2'b00 ? IDLE : AB;
               err_n = ab == 2'b00;
            end
            B2: begin
               state_n = ab == 2'b01 ? B2 : ab == 2'b11 ? AB : IDLE;
               enter_n = ab == 2'b00;
               err_n = ab == 2'b10;
            end
            B1: state_n = ab == 2'b00 ? IDLE : ab == 2'b11 ? BA : B1;
            BA: begin
               state_n = ab == 2'b01 ? B1 : ab == 2'b10 ? A2 : ab == 2'b00 ? IDLE : BA;
               err_n = ab == 2'b00;
            end
            A2: begin
               state_n = ab == 2'b10 ? A2 : ab == 2'b11 ? BA : IDLE;
               leave_n = ab == 2'b00;
               err_n = ab == 2'b01;
            end
            WAIT_CLR: state_n = ab == 2'b00 ? IDLE : WAIT_CLR;
            default: state_n = IDLE;
         endcase
      end
   end
   // state, dwell timer and registered single-cycle outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         dwell <= '0;
         enter <= 1'b0;
         leave <= 1'b0;
         err <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_n;
         dwell <= (state_n != state || state == IDLE || state == WAIT_CLR) ? '0 : dwell + 1'b1;
         enter <= enter_n;
         leave <= leave_n;
         err <= err_n;
         busy <= state_n != IDLE;
      end
   end
endmodule

// File: tb/tb_sbqm_beam_encoder.sv
// tb_sbqm_beam_encoder: directed scenarios plus random beam traffic checked against a passage-progress model
module tb_sbqm_beam_encoder;
   localparam int DEB = 4;
   localparam int TMO = 64;
   logic clk = 1'b0, rst = 1'b1, beam_a = 1'b0, beam_b = 1'b0;
   logic enter, leave, err, busy, a_clean, b_clean;
   int checks = 0, fails = 0, cyc = 0;
   int n_enter = 0, n_leave = 0, n_err = 0, last_enter = -1, last_err = -1;
   bit watch = 0, seen_hi = 0;
   bit m_sa1, m_sa2, m_sb1, m_sb2, m_ca, m_cb;
   bit m_enter, m_leave, m_err, m_busy;
   bit hist_a[$], hist_b[$];
   int pos = 0, stay = 0;

   sbqm_beam_encoder #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .beam_a(beam_a), .beam_b(beam_b),
      .enter(enter), .leave(leave), .err(err), .busy(busy),
      .a_clean(a_clean), .b_clean(b_clean)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // clean level flips once the last DEB synchronized samples all disagree with it
   function automatic bit deb(bit clean, bit h[$]);
      if (h.size() < DEB) return clean;
      for (int i = 1; i <= DEB; i++) if (h[h.size() - i] == clean) return clean;
      return !clean;
   endfunction

   // position of a beam pattern along a passage: nothing, first beam, both, second beam only
   function automatic int idx(bit first, bit second);
      return first ? (second ? 2 : 1) : (second ? 3 : 0);
   endfunction

   // pos: 0 idle, +k = k-th pattern of an entry, -k = k-th pattern of an exit, 9 = waiting for clear
   task automatic model_step();
      int old, d, cur, n;
      if (rst) begin
         {m_sa1, m_sa2, m_sb1, m_sb2, m_ca, m_cb} = '0;
         {m_enter, m_leave, m_err, m_busy} = '0;
         hist_a.delete();
         hist_b.delete();
         pos = 0;
         stay = 0;
         return;
      end
      {m_enter, m_leave, m_err} = '0;
      old = pos;
      if (pos == 0) begin
         if (m_ca && m_cb) begin pos = 9; m_err = 1; end
         else if (m_ca) pos = 1;
         else if (m_cb) pos = -1;
      end else if (pos == 9) begin
         if (!m_ca && !m_cb) pos = 0;
      end else if (stay == TMO - 1) begin
         pos = 9;
         m_err = 1;
      end else begin
         d = pos > 0 ? 1 : -1;
         cur = pos > 0 ? pos : -pos;
         n = d > 0 ? idx(m_ca, m_cb) : idx(m_cb, m_ca);
         if (n == 0) begin
            pos = 0;
            if (cur == 3) begin if (d > 0) m_enter = 1; else m_leave = 1; end
            else if (cur == 2) m_err = 1;
         end else if (n == cur - 1 || n == cur + 1) pos = d * n;
         else if (cur == 3 && n == 1) begin pos = 0; m_err = 1; end
      end
      stay = (pos == old && pos != 0 && pos != 9) ? stay + 1 : 0;
      m_busy = pos != 0;
      hist_a.push_back(m_sa2);
      hist_b.push_back(m_sb2);
      if (hist_a.size() > DEB) void'(hist_a.pop_front());
      if (hist_b.size() > DEB) void'(hist_b.pop_front());
      m_ca = deb(m_ca, hist_a);
      m_cb = deb(m_cb, hist_b);
      m_sa2 = m_sa1;
      m_sb2 = m_sb1;
      m_sa1 = beam_a;
      m_sb1 = beam_b;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      chk("enter", enter, m_enter);
      chk("leave", leave, m_leave);
      chk("err", err, m_err);
      chk("busy", busy, m_busy);
      chk("a_clean", a_clean, m_ca);
      chk("b_clean", b_clean, m_cb);
      if (enter) begin n_enter++; last_enter = cyc; end
      if (leave) n_leave++;
      if (err) begin n_err++; last_err = cyc; end
      if (watch && (a_clean || busy)) seen_hi = 1;
   end

   task automatic drive(bit a, bit b, int n);
      beam_a = a;
      beam_b = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic fwd_walk(output int clr);
      drive(1, 0, 10);
      drive(1, 1, 10);
      drive(0, 1, 10);
      clr = cyc;
      drive(0, 0, 20);
      #2;
   endtask

   initial begin
      int e0, l0, r0, c, len, pat;
      repeat (3) @(negedge clk);
      rst = 0;
      drive(0, 0, 5);
      #2;
      chk_int("idle_after_reset", {enter, leave, err, busy, a_clean, b_clean}, 0);

      e0 = n_enter; l0 = n_leave; r0 = n_err;
      fwd_walk(c);
      chk_int("fwd_enter_count", n_enter - e0, 1);
      chk_int("fwd_latency", last_enter - c, 7);
      chk_int("fwd_no_leave_err", (n_leave - l0) + (n_err - r0), 0);

      e0 = n_enter; l0 = n_leave;
      drive(0, 1, 10);
      drive(1, 1, 10);
      drive(1, 0, 10);
      drive(0, 0, 20);
      #2;
      chk_int("rev_leave_count", n_leave - l0, 1);
      fwd_walk(c);
      chk_int("rev_then_fwd_pulses", (n_enter - e0) + (n_leave - l0), 2);

      watch = 1;
      seen_hi = 0;
      repeat (3) begin
         drive(1, 0, 3);
         drive(0, 0, 6);
      end
      #2;
      watch = 0;
      chk_int("glitch_rejected", seen_hi, 0);

      e0 = n_enter; l0 = n_leave; r0 = n_err;
      drive(1, 0, 10);
      drive(1, 1, 10);
      drive(1, 0, 10);
      drive(0, 0, 20);
      #2;
      chk_int("backtrack_no_pulse", (n_enter - e0) + (n_leave - l0) + (n_err - r0), 0);
      chk_int("backtrack_busy", busy, 0);

      e0 = n_enter; r0 = n_err;
      drive(1, 1, 20);
      #2;
      chk_int("simul_err", n_err - r0, 1);
      chk_int("simul_wait_busy", busy, 1);
      drive(0, 1, 10);
      drive(0, 0, 20);
      #2;
      chk_int("simul_no_more", (n_err - r0) + (n_enter - e0), 1);
      fwd_walk(c);
      chk_int("simul_fresh_enter", n_enter - e0, 1);

      e0 = n_enter; r0 = n_err;
      c = cyc;
      drive(1, 0, 100);
      #2;
      chk_int("timeout_err", n_err - r0, 1);
      chk_int("timeout_at_64", last_err - c, 71);
      chk_int("timeout_busy", busy, 1);
      drive(0, 0, 20);
      #2;
      chk_int("timeout_cleared", busy, 0);
      chk_int("timeout_no_enter", n_enter - e0, 0);

      e0 = n_enter; l0 = n_leave;
      drive(1, 0, 10);
      drive(1, 1, 10);
      drive(0, 1, 10);
      rst = 1;
      @(negedge clk);
      #1;
      chk_int("reset_mid_outputs", {enter, leave, err, busy, a_clean, b_clean}, 0);
      rst = 0;
      drive(0, 1, 9);
      drive(0, 0, 20);
      #2;
      chk_int("reset_mid_no_pulse", (n_enter - e0) + (n_leave - l0), 0);

      for (int i = 0; i < 400; i++) begin
         pat = $urandom_range(0, 3);
         len = ($urandom_range(0, 15) == 0) ? $urandom_range(60, 80) : $urandom_range(1, 12);
         if ($urandom_range(0, 50) == 0) begin
            rst = 1;
            @(negedge clk);
            rst = 0;
         end
         drive(pat[1], pat[0], len);
      end
      drive(0, 0, 30);
      #2;
      chk_int("final_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/sbqm_beam_encoder.md
# sbqm_beam_encoder

Front-end for the bank queue counter. Converts two raw photo-beam sensors mounted across the entrance (beam A outside, beam B inside) into clean, single-cycle `enter` and `leave` event pulses. The pulses drive the queue occupancy counter's increment and decrement requests. The block debounces both beams, decodes direction with a passage state machine, and rejects incomplete, ambiguous or stalled passages.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronized samples required before a debounced beam changes.
- `TIMEOUT`, default 1024: maximum cycles allowed in any non-idle passage state.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `beam_a` in 1: raw outside beam, 1 = blocked, asynchronous.
- `beam_b` in 1: raw inside beam, 1 = blocked, asynchronous.
- `enter` out 1: one-cycle pulse on each completed A→B passage.
- `leave` out 1: one-cycle pulse on each completed B→A passage.
- `err` out 1: one-cycle pulse on an ambiguous or timed-out passage.
- `busy` out 1: high while the FSM is not in IDLE.
- `a_clean`, `b_clean` out 1: debounced beam levels.

## Operation
- **Input path:** each beam passes through a 2-flop synchronizer, then a debouncer.
- **Debouncer:** a counter of width clog2(DEB_CYCLES+1).
  - The counter clears whenever the synchronized value equals the clean value.
  - Otherwise it increments. When it reaches DEB_CYCLES, the clean value toggles and the counter clears.
  - Glitches shorter than DEB_CYCLES samples never reach the FSM.
- **FSM inputs:** (a,b) = (a_clean, b_clean).
- **FSM states:** IDLE, A1, AB, B2, B1, BA, A2, WAIT_CLR.
- **IDLE transitions:**
  - (1,0) → A1.
  - (0,1) → B1.
  - (1,1) → WAIT_CLR with `err`.
- **Entry path (A1 → AB → B2):**
  - A1: (0,0) → IDLE, no pulse. (1,1) → AB.
  - AB: (1,0) → A1. (0,1) → B2. (0,0) → WAIT_CLR-equivalent; go straight to IDLE with `err`.
  - B2: (0,0) → IDLE with `enter`. (1,1) → AB. (1,0) → IDLE with `err`.
- **Exit path (B1 → BA → A2):** mirror image of the entry path with A and B swapped. A2 at (0,0) → IDLE with `leave`.
- **WAIT_CLR:** stay until (0,0), then → IDLE with no pulse.
- **Timeout:**
  - A dwell counter clears on every state change and increments in every state except IDLE and WAIT_CLR.
  - When it reaches TIMEOUT: → WAIT_CLR with `err`. This applies even if a beam changes in the same cycle; timeout has priority.
- **Pulse exclusivity:** at most one of `enter`, `leave`, `err` is high in any cycle. Pulses never stretch beyond one cycle.
- `busy` = (state != IDLE), registered together with the state.

## Timing
- **Reset:** state IDLE, all counters 0, synchronizers 0, `a_clean` = `b_clean` = 0, and `enter`, `leave`, `err`, `busy` = 0. Values apply from the first edge with `rst` high.
- **Reset mid-passage:** the passage is discarded with no pulse. After release, the beams are re-debounced from 0; a beam still blocked is seen as a new rising edge.
- **Input latency:** a raw change stable from edge t gives a clean change at edge t+2+DEB_CYCLES.
- **Output latency:** outputs are registered. A pulse is high during the cycle immediately after the clean level that completes the passage is sampled. Total raw-to-pulse latency is 3+DEB_CYCLES cycles.
- **Back-to-back passages:** a new passage may start in the cycle after a pulse, since IDLE evaluates (a,b) that cycle.

## Test plan
Parameters for all scenarios: DEB_CYCLES=4, TIMEOUT=64.

- **Forward walk:** A=1 for 10 cycles, then A=B=1 for 10, then B=1 for 10, then all clear → exactly one `enter` pulse, 7 cycles after beams clear. No `leave`/`err`.
- **Reverse walk:** B, then BA, then A, then clear → exactly one `leave`. Then repeat the forward walk immediately → one `enter`, total count of pulses 2.
- **Glitch and backtrack:**
  - 3-cycle spikes on A in IDLE → `a_clean` never rises, `busy` stays 0.
  - A, then AB, then A, then clear (person turns back) → no pulses, `busy` returns to 0.
- **Simultaneous block:** A and B rise on the same cycle from IDLE → one `err`, state WAIT_CLR. No further pulse until both clear and a fresh full passage completes.
- **Timeout:** A held 100 cycles → `err` exactly at dwell 64, `busy` stays 1 until A clears, no `enter` afterwards.
- **Reset mid-passage:** forward walk aborted by `rst` pulse in state B2 → all outputs 0 next cycle. Clearing the beams afterwards produces no `enter`.
